// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared widths, stall-vector positions and control levels for the EX/MEM register
package ex_mem_reg_pkg;
  localparam int REG_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int STALL_W_DEF = 6;
  localparam int STALL_EX = 3;
  localparam int CNT_W_DEF = 2;
  localparam int PERF_W_DEF = 32;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
endpackage

// File: rtl/ex_mem_reg_sat_counter.sv
// sat_counter: up-counter with enable that sticks at all-ones, cleared only by async reset
module sat_counter
  import ex_mem_reg_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst == RST_ENABLE) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with stall/flush bubbles, MAC temporary loopback and bubble counter
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STALL_W = STALL_W_DEF,
  parameter int EX_IDX = STALL_EX,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  ex_wd,
  input  logic               ex_wreg,
  input  logic [REG_W-1:0]   ex_wdata,
  input  logic [REG_W-1:0]   ex_hi,
  input  logic [REG_W-1:0]   ex_lo,
  input  logic               ex_whilo,
  input  logic [2*REG_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [ADDR_W-1:0]  mem_wd,
  output logic               mem_wreg,
  output logic [REG_W-1:0]   mem_wdata,
  output logic [REG_W-1:0]   mem_hi,
  output logic [REG_W-1:0]   mem_lo,
  output logic               mem_whilo,
  output logic [2*REG_W-1:0] hilo_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [PERF_W-1:0]  bubble_cnt
);
  logic se, sm, bubble, unused_stall;
  assign se = stall[EX_IDX];
  assign sm = stall[EX_IDX+1];
  assign bubble = !flush && se && !sm;
  assign unused_stall = ^{stall[STALL_W-1:EX_IDX+2], stall[EX_IDX-1:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst == RST_ENABLE) begin
      {mem_wd, mem_wdata, mem_hi, mem_lo, hilo_o, cnt_o} <= '0;
      mem_wreg <= WRITE_DISABLE;
      mem_whilo <= WRITE_DISABLE;
    end else if (flush) begin
      {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o} <= '0;
    end else if (se) begin
      // EX self-stall keeps its MAC temporary alive; MEM only drains to a bubble if it is free
      hilo_o <= hilo_i;
      cnt_o <= cnt_i;
      if (!sm) {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo} <= '0;
    end else begin
      {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo} <=
        {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo};
      hilo_o <= '0;
      cnt_o <= '0;
    end
  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .clk(clk),
    .rst(rst),
    .inc(bubble),
    .q  (bubble_cnt)
  );
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed vectors with hand-computed expectations, plus a 2-bit counter instance for saturation
module tb_ex_mem_reg;
  logic clk = 0, rst = 1, flush = 0, ex_wreg = 0, ex_whilo = 0;
  logic [5:0] stall = 0;
  logic [4:0] ex_wd = 0;
  logic [31:0] ex_wdata = 0, ex_hi = 0, ex_lo = 0;
  logic [63:0] hilo_i = 0;
  logic [1:0] cnt_i = 0;
  logic [4:0] mem_wd, s_wd;
  logic mem_wreg, mem_whilo, s_wreg, s_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, bubble_cnt, s_wdata, s_hi, s_lo;
  logic [63:0] hilo_o, s_hilo;
  logic [1:0] cnt_o, s_cnt, s_bub;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .hilo_o(hilo_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt)
  );

  ex_mem_reg #(.PERF_W(2)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata), .mem_hi(s_hi),
    .mem_lo(s_lo), .mem_whilo(s_whilo), .hilo_o(s_hilo), .cnt_o(s_cnt),
    .bubble_cnt(s_bub)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem_zero(input string tag);
    chk({tag, ".wd"}, 64'(mem_wd), 0);
    chk({tag, ".wreg"}, 64'(mem_wreg), 0);
    chk({tag, ".wdata"}, 64'(mem_wdata), 0);
    chk({tag, ".hi"}, 64'(mem_hi), 0);
    chk({tag, ".lo"}, 64'(mem_lo), 0);
    chk({tag, ".whilo"}, 64'(mem_whilo), 0);
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
  endtask

  always @(negedge clk)
    if (!rst) begin
      compared++;
      assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
      else begin
        mismatched++;
        $error("FAIL illegal_stall: observed %b expected se=1 whenever sm=1", stall);
      end
    end

  initial begin
    tick(); tick();
    chk_mem_zero("rst0");
    chk("rst0.bubble", 64'(bubble_cnt), 0);
    rst = 0;
    set_ex(5'd7, 1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1);
    tick();
    chk("pre_rst.wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    #2 rst = 1;
    #1;
    chk_mem_zero("async_rst");
    chk("async_rst.hilo", hilo_o, 0);
    chk("async_rst.bubble", 64'(bubble_cnt), 0);
    #2 rst = 0;
    tick();
    set_ex(5'd3, 1, 32'h0000_1234, 32'hA, 32'hB, 1);
    hilo_i = 64'h77; cnt_i = 2'd3;
    tick();
    chk("adv.wd", 64'(mem_wd), 3);
    chk("adv.wreg", 64'(mem_wreg), 1);
    chk("adv.wdata", 64'(mem_wdata), 64'h1234);
    chk("adv.hi", 64'(mem_hi), 64'hA);
    chk("adv.lo", 64'(mem_lo), 64'hB);
    chk("adv.whilo", 64'(mem_whilo), 1);
    chk("adv.hilo", hilo_o, 0);
    chk("adv.cnt", 64'(cnt_o), 0);
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    tick();
    chk_mem_zero("bub1");
    chk("bub1.hilo", hilo_o, 64'h1_0000_0002);
    chk("bub1.cnt", 64'(cnt_o), 1);
    chk("bub1.bubble", 64'(bubble_cnt), 1);
    tick();
    chk("bub2.bubble", 64'(bubble_cnt), 2);
    chk("bub2.small", 64'(s_bub), 2);
    tick();
    chk("bub3.bubble", 64'(bubble_cnt), 3);
    chk("bub3.small", 64'(s_bub), 3);
    stall = 0;
    set_ex(5'd9, 1, 32'h55, 32'h0, 32'h0, 0);
    tick();
    chk("hold_load.wdata", 64'(mem_wdata), 64'h55);
    stall = 6'b011111; hilo_i = 64'h5; cnt_i = 2'd2;
    set_ex(5'd1, 0, 32'h99, 32'h3, 32'h4, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold.wdata", 64'(mem_wdata), 64'h55);
      chk("hold.wreg", 64'(mem_wreg), 1);
      chk("hold.wd", 64'(mem_wd), 9);
    end
    chk("hold.bubble", 64'(bubble_cnt), 3);
    chk("hold.hilo", hilo_o, 64'h5);
    chk("hold.cnt", 64'(cnt_o), 2);
    stall = 6'b001111; flush = 1;
    set_ex(5'd4, 1, 32'hCAFE, 32'h6, 32'h7, 1);
    tick();
    chk_mem_zero("flush");
    chk("flush.hilo", hilo_o, 0);
    chk("flush.cnt", 64'(cnt_o), 0);
    chk("flush.bubble", 64'(bubble_cnt), 3);
    chk("flush.small", 64'(s_bub), 3);
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat.small", 64'(s_bub), 3);
    end
    chk("sat.big", 64'(bubble_cnt), 6);
    stall = 0;
    tick();
    chk("final.wdata", 64'(mem_wdata), 64'hCAFE);
    chk("final.cnt", 64'(cnt_o), 0);
    chk("final.hilo", hilo_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core. It latches the EX results each cycle: register write-back address/enable/data and the HI/LO write request. It implements the stall-vector and flush protocol, inserting bubbles when EX stalls but MEM does not. It also carries the two-cycle multiply-accumulate temporaries (hilo_temp, cnt) back to EX, and keeps a saturating bubble counter for performance debug.

Parameters:
REG_W, 32, general register / HI / LO width
ADDR_W, 5, register-file address width
STALL_W, 6, width of the pipeline stall vector (pc, if, id, ex, mem, wb)
EX_IDX, 3, stall-vector bit for the EX stage; EX_IDX+1 is the MEM stage
CNT_W, 2, multi-cycle op cycle-counter width
PERF_W, 32, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high (`RstEnable = 1'b1)
stall  in  STALL_W  stall vector from the control unit
flush  in  1  synchronous pipeline flush (exception/eret)
ex_wd  in  ADDR_W  EX destination register
ex_wreg  in  1  EX register write enable
ex_wdata  in  REG_W  EX result
ex_hi  in  REG_W  EX HI value
ex_lo  in  REG_W  EX LO value
ex_whilo  in  1  EX HI/LO write enable
hilo_i  in  2*REG_W  EX multiply-accumulate temporary {hi,lo}
cnt_i  in  CNT_W  EX multi-cycle counter
mem_wd  out  ADDR_W  to MEM
mem_wreg  out  1  to MEM
mem_wdata  out  REG_W  to MEM
mem_hi  out  REG_W  to MEM
mem_lo  out  REG_W  to MEM
mem_whilo  out  1  to MEM; also the MEM HI/LO forwarding enable into EX
hilo_o  out  2*REG_W  temporary returned to EX
cnt_o  out  CNT_W  counter returned to EX
bubble_cnt  out  PERF_W  saturating count of bubbles inserted

Behaviour:
- All outputs are registered. There is no combinational path from input to output.
- Asynchronous reset: every output goes to 0 (mem_wreg/mem_whilo = `WriteDisable). bubble_cnt is cleared only by rst.
- Let se = stall[EX_IDX] and sm = stall[EX_IDX+1]. Per-edge priority, highest first:
  1. flush=1: all mem_* outputs, hilo_o and cnt_o are set to 0. bubble_cnt is not incremented. Flush overrides any stall.
  2. se=1, sm=0 (bubble): all mem_* outputs are set to 0. hilo_o<=hilo_i and cnt_o<=cnt_i. bubble_cnt increments.
  3. se=1, sm=1 (hold): all mem_* outputs keep their value. hilo_o<=hilo_i and cnt_o<=cnt_i.
  4. se=0 (advance): mem_* outputs load the corresponding ex_* inputs. hilo_o<=0 and cnt_o<=0.
- se=0 with sm=1 is an illegal control-unit state. The block treats it as advance, and the bench asserts it never occurs.
- Latency: one cycle from EX to MEM when not stalled.
- hilo_o/cnt_o loopback gives the EX stage a one-cycle-later copy of its own temporary. A multi-cycle madd/msub therefore survives its self-stall. The temporary is cleared as soon as EX advances.
- bubble_cnt saturates at all-ones and never wraps.
- Reset asserted mid-stall clears everything immediately. After reset release, the next edge applies the normal rules.

Decomposition:
- Shared define package (existing define.v): `RstEnable, `WriteEnable/`WriteDisable, `ZeroWord, `RegBus, `RegAddrBus, `DoubleRegBus, and the stall-vector bit positions. No new typedefs are needed.
- One natural sub-module: sat_counter (parameterised width, inc enable, async clear). It implements bubble_cnt and is reusable by other stage registers.

Test Plan:
- Reset: assert rst mid-cycle with ex_wdata=32'hDEAD_BEEF applied -> all outputs 0 immediately, before any clock edge; bubble_cnt=0.
- Advance: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h0000_1234, ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB -> next edge: mem_wd=3, mem_wreg=1, mem_wdata=32'h1234, mem_hi=32'hA, mem_lo=32'hB, mem_whilo=1; hilo_o=0, cnt_o=0.
- Bubble: stall=6'b001111, hilo_i=64'h1_0000_0002, cnt_i=2'd1 -> mem_* all 0; hilo_o=64'h1_0000_0002, cnt_o=1; bubble_cnt increments by 1 per stalled cycle (3 cycles -> 3).
- Hold: load mem_wdata=32'h55, then stall=6'b011111 for 4 cycles -> mem_wdata stays 32'h55, mem_wreg is unchanged, bubble_cnt is unchanged.
- Flush priority: flush=1 with stall=6'b001111 and valid EX data -> all mem_*, hilo_o and cnt_o are 0; bubble_cnt is not incremented.
- Saturation: force bubble_cnt to 32'hFFFF_FFFE via PERF_W=2 instance (preload 2'b10), apply 3 bubble cycles -> count reads 2'b11 and stays 2'b11.
